pid_heater_controller: RTL
==========================

# pid_heater_controller

Sampled PID engine for the water-heater loop, directly downstream of the command-decode stage. It consumes the decoded SETPOINT and the PROPORTIONAL, INTEGRAL and DERIVATIVE gain registers together with a measured temperature. On each sample strobe it computes a saturated heater duty cycle on a shared multiply-accumulate datapath, then drives the heater through a glitch-free PWM output.

## Interface
- WIDTH, 14: width of setpoint, temperature and gain inputs.
- OUT_WIDTH, 10: duty-cycle and PWM counter width.
- INT_LIMIT, 65535: symmetric saturation bound of the integral accumulator (±INT_LIMIT).

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SETPOINT  in  14  target temperature, unsigned, already clamped upstream.
- PROPORTIONAL  in  14  Kp, unsigned Q6.8 (256 = 1.0).
- INTEGRAL  in  14  Ki, unsigned Q6.8.
- DERIVATIVE  in  14  Kd, unsigned Q6.8.
- TEMP  in  14  measured temperature, unsigned, same scale as SETPOINT.
- SAMPLE  in  1  one-cycle request to run one PID update.
- BUSY  out  1  high while a computation is in progress.
- DUTY  out  10  latest saturated duty value.
- DUTY_VALID  out  1  one-cycle pulse when DUTY updates.
- PWM_OUT  out  1  heater drive.

## Operation
- FSM states: IDLE -> CALC -> MUL_P -> MUL_I -> MUL_D -> SAT -> IDLE. It advances one state per clock. BUSY = (state != IDLE).
- IDLE: if SAMPLE=1, register SETPOINT, TEMP and all three gains, then go to CALC. SAMPLE is ignored in every other state, with no queueing.
- CALC:
  - e = SETPOINT − TEMP (15-bit signed).
  - d = e − e_prev (16-bit signed).
  - acc = sat(acc + e, ±INT_LIMIT), with acc an 18-bit signed register.
- MUL_P: sum = Kp·e. MUL_I: sum += Ki·acc. MUL_D: sum += Kd·d.
  - Use a single shared signed multiplier; gains are zero-extended.
  - sum is 34-bit signed and cannot overflow.
- SAT:
  - q = sum >>> 8 (arithmetic shift).
  - DUTY = 0 if q<0; 1023 if q>1023; else q[9:0].
  - Pulse DUTY_VALID, set e_prev = e, return to IDLE.
- e_prev resets to 0, so the first sample's derivative term equals e.
- PWM:
  - Free-running OUT_WIDTH counter 0..1023 that wraps to 0.
  - duty_active loads from DUTY only on the cycle the counter is 0.
  - PWM_OUT = (counter < duty_active), registered.
  - DUTY=0 gives a constant low output; DUTY=1023 gives 1023 high cycles per 1024.

## Timing
- Reset, while RST=1 at a clock edge:
  - state=IDLE.
  - DUTY, duty_active, DUTY_VALID, BUSY, PWM_OUT, counter, acc, e_prev, sum all 0.
- Reset mid-computation aborts the computation. No DUTY_VALID pulse is produced and the integrator is cleared.
- Latency: SAMPLE sampled high at edge N gives BUSY high from edge N to edge N+5. DUTY updates and DUTY_VALID is high for exactly the cycle following edge N+5.
- Back-to-back rate: SAMPLE held high gives a new update every 6 cycles.
- A SAMPLE coincident with the SAT cycle is ignored. The first accepted SAMPLE is the one seen in IDLE.
- A new DUTY reaches PWM_OUT at the next counter wrap, i.e. 1–1024 cycles later. The PWM period is never truncated.
- Inputs need only be stable at the accepting edge. Later changes do not affect the computation in progress.

## Test plan
- Proportional: Kp=256, Ki=Kd=0, SETPOINT=5000, TEMP=4800, one SAMPLE -> DUTY_VALID pulse 6 cycles after the accepting edge, DUTY=200. With TEMP=6000 -> DUTY=0. With SETPOINT=12800, TEMP=0 -> DUTY=1023.
- Integral and windup: Kp=Kd=0, Ki=256, e=100, three samples -> DUTY=100, 200, 300. Ki=1, e=16000, six samples -> acc 16000, 32000, 48000, 64000, 65535, 65535 and DUTY=62, 125, 187, 250, 255, 255.
- Derivative: Kp=Ki=0, Kd=256, e=100 then e=150 -> DUTY=100, then 50. Then e=100 -> d=−50 -> DUTY=0.
- Busy handling: pulse SAMPLE at each of the 5 busy cycles -> exactly one DUTY_VALID and BUSY never stretched. SAMPLE held high for 18 cycles -> exactly 3 DUTY_VALID pulses, 6 cycles apart.
- PWM: DUTY=256 -> PWM_OUT high exactly 256 of every 1024 cycles, starting at counter 0. Change DUTY to 512 mid-period -> the current period still uses 256 and the next period uses 512.
- Reset: assert RST during MUL_I after accumulated windup -> no DUTY_VALID, all outputs 0. A following sample with Kp=0, Ki=256, e=10 -> DUTY=10, proving acc was cleared.

Source files
------------

// File: rtl/pid_heater_controller_if.sv
// Sample/result bundle between the command-decode stage and the PID heater engine.
// Handshake: sample is a one-cycle request, taken only on an edge where busy is low;
// a request seen while busy is dropped, and duty_valid pulses once when duty updates.
interface pid_heater_controller_if #(
   parameter int WIDTH     = 14,
   parameter int OUT_WIDTH = 10
);
   logic [WIDTH-1:0]     setpoint;
   logic [WIDTH-1:0]     proportional;
   logic [WIDTH-1:0]     integral;
   logic [WIDTH-1:0]     derivative;
   logic [WIDTH-1:0]     temp;
   logic                 sample;
   logic                 busy;
   logic [OUT_WIDTH-1:0] duty;
   logic                 duty_valid;

   modport master (
      output setpoint, proportional, integral, derivative, temp, sample,
      input  busy, duty, duty_valid
   );

   modport slave (
      input  setpoint, proportional, integral, derivative, temp, sample,
      output busy, duty, duty_valid
   );
endinterface

// File: rtl/pid_heater_controller.sv
// Sampled PID engine: one shared signed multiplier walks P, I and D terms, then
// saturates to a duty cycle that drives a period-aligned PWM output.
module pid_heater_controller #(
   parameter int WIDTH     = 14,
   parameter int OUT_WIDTH = 10,
   parameter int INT_LIMIT = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   pid_heater_controller_if.slave  bus,
   output logic                    pwm_out,
   output logic [2:0]              state_dbg
);

   localparam int E_W    = WIDTH + 1;
   localparam int D_W    = WIDTH + 2;
   localparam int ACC_W  = 18;
   localparam int PROD_W = WIDTH + 1 + ACC_W;
   localparam int SUM_W  = 34;
   localparam logic signed [ACC_W:0] LIM_POS = (ACC_W + 1)'(INT_LIMIT);
   localparam logic signed [ACC_W:0] LIM_NEG = -LIM_POS;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      MUL_P = 3'd2,
      MUL_I = 3'd3,
      MUL_D = 3'd4,
      SAT   = 3'd5
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]         sp_r, temp_r, kp_r, ki_r, kd_r;
   logic signed [E_W-1:0]    e_r, e_prev, e_calc;
   logic signed [D_W-1:0]    d_r, d_calc;
   logic signed [ACC_W-1:0]  acc, acc_next;
   logic signed [ACC_W:0]    acc_sum;
   logic signed [SUM_W-1:0]  sum, q;
   logic signed [WIDTH:0]    mul_a;
   logic signed [ACC_W-1:0]  mul_b;
   logic signed [PROD_W-1:0] prod;
   logic [OUT_WIDTH-1:0]     duty_r, duty_sat;
   logic                     duty_valid_r;

   logic [OUT_WIDTH-1:0]     pwm_cnt, duty_active, duty_eff;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.sample) state_next = CALC;
         CALC:    state_next = MUL_P;
         MUL_P:   state_next = MUL_I;
         MUL_I:   state_next = MUL_D;
         MUL_D:   state_next = SAT;
         SAT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state != IDLE);
      state_dbg = state;
   end

   // Error terms are formed from the captured operands, so inputs may move after acceptance.
   always_comb begin
      e_calc  = E_W'(sp_r) - E_W'(temp_r);
      d_calc  = D_W'(e_calc) - D_W'(e_prev);
      acc_sum = (ACC_W + 1)'(acc) + (ACC_W + 1)'(e_calc);
      if (acc_sum > LIM_POS)      acc_next = LIM_POS[ACC_W-1:0];
      else if (acc_sum < LIM_NEG) acc_next = LIM_NEG[ACC_W-1:0];
      else                        acc_next = acc_sum[ACC_W-1:0];
   end

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state)
         MUL_P: begin
            mul_a = {1'b0, kp_r};
            mul_b = ACC_W'(e_r);
         end
         MUL_I: begin
            mul_a = {1'b0, ki_r};
            mul_b = acc;
         end
         MUL_D: begin
            mul_a = {1'b0, kd_r};
            mul_b = ACC_W'(d_r);
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase
      prod = mul_a * mul_b;
   end

   always_comb begin
      q = sum >>> 8;
      if (q[SUM_W-1])                 duty_sat = '0;
      else if (|q[SUM_W-2:OUT_WIDTH]) duty_sat = '1;
      else                            duty_sat = q[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_r         <= '0;
         temp_r       <= '0;
         kp_r         <= '0;
         ki_r         <= '0;
         kd_r         <= '0;
         e_r          <= '0;
         d_r          <= '0;
         e_prev       <= '0;
         acc          <= '0;
         sum          <= '0;
         duty_r       <= '0;
         duty_valid_r <= 1'b0;
      end else begin
         duty_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.sample) begin
                  sp_r   <= bus.setpoint;
                  temp_r <= bus.temp;
                  kp_r   <= bus.proportional;
                  ki_r   <= bus.integral;
                  kd_r   <= bus.derivative;
               end
            end
            CALC: begin
               e_r <= e_calc;
               d_r <= d_calc;
               acc <= acc_next;
            end
            MUL_P:        sum <= SUM_W'(prod);
            MUL_I, MUL_D: sum <= sum + SUM_W'(prod);
            SAT: begin
               duty_r       <= duty_sat;
               duty_valid_r <= 1'b1;
               e_prev       <= e_r;
            end
            default: ;
         endcase
      end
   end

   assign bus.duty       = duty_r;
   assign bus.duty_valid = duty_valid_r;

   // A new duty is only picked up at counter zero so a period is never cut short.
   always_comb duty_eff = (pwm_cnt == '0) ? duty_r : duty_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt     <= '0;
         duty_active <= '0;
         pwm_out     <= 1'b0;
      end else begin
         pwm_cnt     <= pwm_cnt + 1'b1;
         duty_active <= duty_eff;
         pwm_out     <= (pwm_cnt < duty_eff);
      end
   end

endmodule
